cache_msg_arbiter: RTL and testbench

- Coherence message bus controller shared by `cache_num` cache controllers.
- Arbitrates the per-cache `msg_req`/`msg` requests round-robin and grants one cache at a time.
- Broadcasts the granted message on `msg_in`/`msg_in_valid` to every other cache.
- Holds the bus until each receiver acknowledges or a timeout expires, so only one coherence transaction is in flight.

---
 rtl/cache_msg_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/cache_msg_arbiter.sv | 149 ++++++++++++++
 tb/tb_cache_msg_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_msg_pkg.sv
// Shared types and field-width helpers for the coherence message bus arbiter.
package cache_msg_pkg;

    localparam int unsigned TYPE_W = 4;

    typedef enum logic [TYPE_W-1:0] {
        MSG_RD   = 4'h0,
        MSG_RDX  = 4'h1,
        MSG_UPG  = 4'h2,
        MSG_INV  = 4'h3,
        MSG_WB   = 4'h4,
        MSG_DATA = 4'h5
    } msg_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GNT      = 2'd1,
        ST_BCAST    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_e;

    function automatic int unsigned id_w(input int unsigned n_caches);
        return $clog2(n_caches);
    endfunction

    // Message layout, MSB first: {type, src_id, dst_id, addr}
    function automatic int unsigned msg_w(input int unsigned n_caches,
                                          input int unsigned a_width);
        return TYPE_W + 2 * id_w(n_caches) + a_width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned n_req = 2,
    parameter int unsigned idx_w = 1
) (
    input  logic [n_req-1:0] req_i,
    input  logic [idx_w-1:0] ptr_i,
    output logic [n_req-1:0] gnt_oh_c_o,
    output logic [idx_w-1:0] gnt_idx_c_o,
    output logic             any_c_o
);

    always_comb begin
        int unsigned j;
        logic [idx_w-1:0] idx;
        logic found;
        gnt_oh_c_o  = '0;
        gnt_idx_c_o = '0;
        found       = 1'b0;
        j           = 0;
        idx         = '0;
        for (int unsigned i = 0; i < n_req; i++) begin
            j = 32'(ptr_i) + i;
            if (j >= n_req) j = j - n_req;
            idx = idx_w'(j);
            if (!found && req_i[idx]) begin
                found            = 1'b1;
                gnt_oh_c_o[idx]  = 1'b1;
                gnt_idx_c_o      = idx;
            end
        end
        any_c_o = found;
    end

endmodule

// File: rtl/cache_msg_arbiter.sv
// Coherence bus controller: round-robin grant, broadcast to all other caches,
// then hold the bus until every receiver acks or the ack timeout expires.
module cache_msg_arbiter
    import cache_msg_pkg::*;
#(
    parameter int unsigned cache_num   = 2,
    parameter int unsigned addr_width  = 32,
    parameter int unsigned ack_timeout = 256,
    localparam int unsigned ID_W  = id_w(cache_num),
    localparam int unsigned MSG_W = msg_w(cache_num, addr_width)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [cache_num-1:0]       msg_req_i,
    input  logic [cache_num*MSG_W-1:0] msg_i,
    output logic [cache_num-1:0]       msg_gnt_o,
    output logic [cache_num-1:0]       msg_in_valid_o,
    output logic [MSG_W-1:0]           msg_in_o,
    input  logic [cache_num-1:0]       msg_ack_i,
    output logic                       busy_o,
    output logic                       timeout_err_o
);

    localparam int unsigned CNT_W   = $clog2(ack_timeout);
    localparam int unsigned SRC_LSB = addr_width + ID_W;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      win_q, win_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [cache_num-1:0] gnt_q, gnt_d;
    logic [cache_num-1:0] valid_q, valid_d;
    logic [MSG_W-1:0]     msg_in_q, msg_in_d;
    logic [cache_num-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 terr_q, terr_d;

    logic [cache_num-1:0] arb_oh;
    logic [ID_W-1:0]      arb_idx;
    logic                 arb_any;

    logic [MSG_W-1:0]     msg_arr [cache_num];
    logic [MSG_W-1:0]     win_msg;
    logic [MSG_W-1:0]     stamped_msg;
    logic [cache_num-1:0] sender_oh;
    logic [cache_num-1:0] remaining;
    logic [ID_W-1:0]      next_ptr;

    rr_arbiter #(
        .n_req (cache_num),
        .idx_w (ID_W)
    ) u_rr_arbiter (
        .req_i       (msg_req_i),
        .ptr_i       (rr_ptr_q),
        .gnt_oh_c_o  (arb_oh),
        .gnt_idx_c_o (arb_idx),
        .any_c_o     (arb_any)
    );

    for (genvar g = 0; g < cache_num; g++) begin : g_unpack
        assign msg_arr[g] = msg_i[g*MSG_W +: MSG_W];
    end

    // Source field is forced to the granted index so a requester cannot spoof it
    assign win_msg     = msg_arr[win_q];
    assign stamped_msg = {win_msg[MSG_W-1 -: TYPE_W], win_q, win_msg[SRC_LSB-1:0]};
    assign sender_oh   = cache_num'(1) << win_q;
    assign remaining   = pending_q & ~msg_ack_i;
    assign next_ptr    = (win_q == ID_W'(cache_num - 1)) ? '0 : win_q + ID_W'(1);

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = '0;
        valid_d   = '0;
        msg_in_d  = msg_in_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    win_d   = arb_idx;
                    gnt_d   = arb_oh;
                    state_d = ST_GNT;
                end
            end
            ST_GNT: begin
                msg_in_d = stamped_msg;
                valid_d  = ~sender_oh;
                state_d  = ST_BCAST;
            end
            ST_BCAST: begin
                pending_d = ~sender_oh;
                cnt_d     = '0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                pending_d = remaining;
                if (remaining == '0) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (cnt_q == CNT_W'(ack_timeout - 1)) begin
                    terr_d   = 1'b1;
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            valid_q   <= '0;
            msg_in_q  <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            msg_in_q  <= msg_in_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            terr_q    <= terr_d;
        end
    end

    assign msg_gnt_o      = gnt_q;
    assign msg_in_valid_o = valid_q;
    assign msg_in_o       = msg_in_q;
    assign busy_o         = busy_q;
    assign timeout_err_o  = terr_q;

endmodule

// File: tb/tb_cache_msg_arbiter.sv
// Self-checking bench for cache_msg_arbiter: directed scenarios plus random
// transactions predicted by a transaction-level model.
module tb_cache_msg_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned TO    = 8;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned MSG_W = 4 + 2 * ID_W + AW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         msg_req;
    logic [N*MSG_W-1:0]   msg;
    logic [N-1:0]         msg_gnt;
    logic [N-1:0]         msg_in_valid;
    logic [MSG_W-1:0]     msg_in;
    logic [N-1:0]         msg_ack;
    logic                 busy;
    logic                 timeout_err;

    int                   n_checks = 0;
    int                   n_fails  = 0;
    int                   exp_ptr;
    logic                 exp_terr;
    logic [N-1:0]         sched [TO];
    logic [3:0]           mtype [N];
    logic [ID_W-1:0]      msrc  [N];
    logic [ID_W-1:0]      mdst  [N];
    logic [AW-1:0]        maddr [N];

    cache_msg_arbiter #(
        .cache_num   (N),
        .addr_width  (AW),
        .ack_timeout (TO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .msg_req_i      (msg_req),
        .msg_i          (msg),
        .msg_gnt_o      (msg_gnt),
        .msg_in_valid_o (msg_in_valid),
        .msg_in_o       (msg_in),
        .msg_ack_i      (msg_ack),
        .busy_o         (busy),
        .timeout_err_o  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < int'(N); i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic new_msg(input int i);
        mtype[i] = 4'($urandom);
        msrc[i]  = ID_W'($urandom);
        mdst[i]  = ID_W'($urandom);
        maddr[i] = $urandom;
    endtask

    task automatic drive_msgs();
        for (int i = 0; i < int'(N); i++)
            msg[i*MSG_W +: MSG_W] = {mtype[i], msrc[i], mdst[i], maddr[i]};
    endtask

    task automatic fill_sched(input logic [N-1:0] v);
        for (int k = 0; k < int'(TO); k++) sched[k] = v;
    endtask

    // One transaction from IDLE; early drives acks during GNT/BCAST, rst_k pulses rst in WAIT_ACK
    task automatic run_txn(input logic [N-1:0] req, input bit early, input int rst_k);
        int w;
        logic [N-1:0] rcv, cov;
        logic [MSG_W-1:0] em;
        bit done;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("drain_idle", busy, 0);
        w = pick(req, exp_ptr);
        drive_msgs();
        msg_req = req;
        msg_ack = '0;
        tick();
        if (w < 0) begin
            chk("noreq_busy", busy, 0);
            chk("noreq_gnt", msg_gnt, 0);
            return;
        end
        chk("gnt", msg_gnt, N'(1) << w);
        chk("busy_gnt", busy, 1);
        em  = {mtype[w], ID_W'(w), mdst[w], maddr[w]};
        rcv = ~(N'(1) << w);
        msg_req = req & ~(N'(1) << w);
        if (early) msg_ack = '1;
        tick();
        chk("bcast_msg", msg_in, em);
        chk("bcast_valid", msg_in_valid, rcv);
        chk("gnt_pulse", msg_gnt, 0);
        tick();
        chk("valid_pulse", msg_in_valid, 0);
        new_msg(w);
        drive_msgs();
        cov  = '0;
        done = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            if (k == rst_k) begin
                rst     = 1'b1;
                msg_ack = '0;
                msg_req = '0;
                tick();
                rst      = 1'b0;
                exp_ptr  = 0;
                exp_terr = 1'b0;
                chk("rst_gnt", msg_gnt, 0);
                chk("rst_valid", msg_in_valid, 0);
                chk("rst_msg", msg_in, 0);
                chk("rst_busy", busy, 0);
                chk("rst_terr", timeout_err, 0);
                return;
            end
            msg_ack = early ? '0 : sched[k];
            cov = cov | msg_ack;
            if ((cov & rcv) == rcv) begin
                done = 1'b1;
            end else if (k == int'(TO) - 1) begin
                done     = 1'b1;
                exp_terr = 1'b1;
            end
            tick();
            chk("wait_busy", busy, !done);
            chk("terr", timeout_err, exp_terr);
            chk("msg_hold", msg_in, em);
            if (done) break;
        end
        msg_ack = '0;
        exp_ptr = (w + 1) % N;
    endtask

    initial begin
        rst      = 1'b1;
        msg_req  = '0;
        msg_ack  = '0;
        msg      = '0;
        exp_ptr  = 0;
        exp_terr = 1'b0;
        for (int i = 0; i < int'(N); i++) new_msg(i);
        tick();
        tick();
        chk("reset_gnt", msg_gnt, 0);
        chk("reset_valid", msg_in_valid, 0);
        chk("reset_msg", msg_in, 0);
        chk("reset_busy", busy, 0);
        chk("reset_terr", timeout_err, 0);
        rst = 1'b0;

        // All caches request continuously: grants rotate 0,1,2,3,0
        fill_sched('1);
        for (int t = 0; t < 5; t++) run_txn(4'b1111, 1'b0, -1);

        // Single requester, partial acks then the rest one cycle later
        mtype[1] = 4'h3; mdst[1] = '0; maddr[1] = 32'h1000;
        fill_sched('0);
        sched[0] = 4'b0001;
        sched[1] = 4'b1100;
        run_txn(4'b0010, 1'b0, -1);

        // Spoofed source id is replaced with the granted index
        msrc[2] = '0;
        fill_sched('1);
        run_txn(4'b0100, 1'b0, -1);

        // All receivers ack in the same later cycle
        fill_sched('0);
        sched[2] = 4'b1111;
        run_txn(4'b1001, 1'b0, -1);

        // Sender-only acks never close the transaction: timeout
        fill_sched(4'b1000);
        run_txn(4'b1000, 1'b0, -1);

        // Next request still granted; timeout_err stays sticky
        fill_sched('1);
        run_txn(4'b0001, 1'b0, -1);

        // Acks during GNT/BCAST are ignored: timeout
        run_txn(4'b0110, 1'b1, -1);

        // No requests: arbiter stays idle
        run_txn(4'b0000, 1'b0, -1);

        // Random traffic
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < int'(TO); k++)
                sched[k] = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            run_txn(N'($urandom), 1'b0, -1);
        end

        // Reset during WAIT_ACK clears pointer and sticky error
        fill_sched('1);
        run_txn(4'b0010, 1'b0, -1);
        fill_sched('0);
        run_txn(4'b0100, 1'b0, 2);
        fill_sched('1);
        run_txn(4'b1010, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
